// File: rtl/gcd_job_ctrl_if.sv
// Bundle of the upstream operand handshake, the GCD core start/done link and
// the downstream result handshake. The controller uses master; its surroundings use slave.
interface gcd_job_ctrl_if #(
  parameter int W  = 8,
  parameter int CW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_p;
  logic [W-1:0]  in_q;

  logic          core_start;
  logic [W-1:0]  core_P;
  logic [W-1:0]  core_Q;
  logic [W-1:0]  core_R;
  logic          core_done;

  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_gcd;
  logic [W-1:0]  out_p;
  logic [W-1:0]  out_q;
  logic [CW-1:0] out_cycles;

  modport master (
    input  in_valid, in_p, in_q, core_R, core_done, out_ready,
    output in_ready, core_start, core_P, core_Q,
           out_valid, out_gcd, out_p, out_q, out_cycles
  );

  modport slave (
    output in_valid, in_p, in_q, core_R, core_done, out_ready,
    input  in_ready, core_start, core_P, core_Q,
           out_valid, out_gcd, out_p, out_q, out_cycles
  );
endinterface

// File: rtl/gcd_job_ctrl.sv
// Job sequencer in front of the GCD core: resolves zero-operand jobs locally,
// runs all others on the core and returns result, operands and cycle count.
module gcd_job_ctrl #(
  parameter int W  = 8,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            rst,
  gcd_job_ctrl_if.master  bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] OUT   = 3'd4;

  localparam logic [CW-1:0] CYCLES_MAX = {CW{1'b1}};

  logic [2:0]    r_state;
  logic          r_inReady;
  logic          r_coreStart;
  logic [W-1:0]  r_coreP;
  logic [W-1:0]  r_coreQ;
  logic          r_outValid;
  logic [W-1:0]  r_outGcd;
  logic [W-1:0]  r_outP;
  logic [W-1:0]  r_outQ;
  logic [CW-1:0] r_cycles;

  logic          w_accept;
  logic          w_zeroJob;

  assign w_accept  = bus.in_valid && r_inReady;
  assign w_zeroJob = (bus.in_p == '0) || (bus.in_q == '0);

  // The core never finishes when exactly one operand is zero, so such jobs
  // bypass it; DRAIN waits for done to drop so a stale level is never reused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_inReady   <= 1'b1;
      r_coreStart <= 1'b0;
      r_coreP     <= '0;
      r_coreQ     <= '0;
      r_outValid  <= 1'b0;
      r_outGcd    <= '0;
      r_outP      <= '0;
      r_outQ      <= '0;
      r_cycles    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_inReady <= 1'b0;
            r_outP    <= bus.in_p;
            r_outQ    <= bus.in_q;
            r_cycles  <= '0;
            if (w_zeroJob) begin
              r_outGcd   <= bus.in_p | bus.in_q;
              r_outValid <= 1'b1;
              r_state    <= OUT;
            end else begin
              r_coreP <= bus.in_p;
              r_coreQ <= bus.in_q;
              r_state <= LOAD;
            end
          end
        end
        LOAD: begin
          r_coreStart <= 1'b1;
          r_state     <= RUN;
        end
        RUN: begin
          if (bus.core_done) begin
            r_outGcd    <= bus.core_R;
            r_coreStart <= 1'b0;
            r_state     <= DRAIN;
          end else if (r_cycles != CYCLES_MAX) begin
            r_cycles <= r_cycles + CW'(1);
          end
        end
        DRAIN: begin
          if (!bus.core_done) begin
            r_outValid <= 1'b1;
            r_state    <= OUT;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_inReady   <= 1'b1;
          r_coreStart <= 1'b0;
          r_outValid  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = r_inReady;
  assign bus.core_start = r_coreStart;
  assign bus.core_P     = r_coreP;
  assign bus.core_Q     = r_coreQ;
  assign bus.out_valid  = r_outValid;
  assign bus.out_gcd    = r_outGcd;
  assign bus.out_p      = r_outP;
  assign bus.out_q      = r_outQ;
  assign bus.out_cycles = r_cycles;

endmodule

// File: tb/tb_gcd_job_ctrl.sv
// Directed bench for gcd_job_ctrl, with a behavioural subtract/swap GCD core
// wired to the controller's start/done link and reset from ~rst.
module tb_gcd_job_ctrl;

  localparam int W  = 8;
  localparam int CW = 16;

  logic clk;
  logic rst;
  logic coreRstN;

  int checks = 0;
  int errors = 0;
  int lat;
  int startBase;
  int startRises = 0;
  logic prevStart = 1'b0;

  gcd_job_ctrl_if #(.W(W), .CW(CW)) bus ();

  gcd_job_ctrl #(.W(W), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: S0 loads operands while start is low, S1 compares,
  // SUB/SWAP take one cycle each, S2 holds done until start drops.
  localparam logic [2:0] C_S0 = 3'd0, C_S1 = 3'd1, C_SUB = 3'd2, C_SWAP = 3'd3, C_S2 = 3'd4;
  logic [2:0]   coreState;
  logic [W-1:0] cP, cQ;

  assign coreRstN      = ~rst;
  assign bus.core_R    = cP;
  assign bus.core_done = (coreState == C_S2);

  always @(posedge clk or negedge coreRstN) begin
    if (!coreRstN) begin
      coreState <= C_S0;
      cP        <= '0;
      cQ        <= '0;
    end else begin
      case (coreState)
        C_S0:   if (bus.core_start) coreState <= C_S1;
                else begin cP <= bus.core_P; cQ <= bus.core_Q; end
        C_S1:   if (cP == cQ) coreState <= C_S2;
                else if (cP < cQ) coreState <= C_SWAP;
                else coreState <= C_SUB;
        C_SUB:  begin cP <= cP - cQ; coreState <= C_S1; end
        C_SWAP: begin cP <= cQ; cQ <= cP; coreState <= C_S1; end
        C_S2:   if (!bus.core_start) coreState <= C_S0;
        default: coreState <= C_S0;
      endcase
    end
  end

  always @(posedge clk) begin
    if (bus.core_start && !prevStart) startRises <= startRises + 1;
    prevStart <= bus.core_start;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Waits for in_ready, offers the pair and returns at the negedge after the accept edge.
  task automatic applyStimulus(input logic [W-1:0] p, input logic [W-1:0] q, input bit hold);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("in_ready wait", 64'(n < 100), 64'd1);
    bus.in_p     = p;
    bus.in_q     = q;
    bus.in_valid = 1'b1;
    @(negedge clk);
    if (!hold) bus.in_valid = 1'b0;
  endtask

  // Counts edges from accept (accept edge = 1) until out_valid is seen high.
  task automatic waitOutValid(output int edges);
    edges = 1;
    while (bus.out_valid !== 1'b1 && edges < 3000) begin
      @(negedge clk);
      edges++;
    end
    checkOutput("out_valid timeout", 64'(edges < 3000), 64'd1);
  endtask

  task automatic checkJob(input string tag, input int expGcd, input int expP, input int expQ, input int expCyc);
    checkOutput({tag, " gcd"},    64'(bus.out_gcd),    64'(expGcd));
    checkOutput({tag, " p/q"},    64'({bus.out_p, bus.out_q}), 64'({8'(expP), 8'(expQ)}));
    checkOutput({tag, " cycles"}, 64'(bus.out_cycles), 64'(expCyc));
  endtask

  task automatic runJob(input string tag, input int p, input int q, input int expGcd,
                        input int expCyc, input int expLat);
    startBase = startRises;
    applyStimulus(W'(p), W'(q), 1'b0);
    waitOutValid(lat);
    checkJob(tag, expGcd, p, q, expCyc);
    checkOutput({tag, " latency"}, 64'(lat), 64'(expLat));
    @(negedge clk);
    checkOutput({tag, " start pulses"}, 64'(startRises - startBase), 64'((expCyc == 0) ? 0 : 1));
    checkOutput({tag, " out_valid drop"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_p      = '0;
    bus.in_q      = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] reset values");
    checkOutput("rst in_ready",   64'(bus.in_ready),   64'd1);
    checkOutput("rst core_start", 64'(bus.core_start), 64'd0);
    checkOutput("rst out_valid",  64'(bus.out_valid),  64'd0);
    checkOutput("rst core_PQ",    64'({bus.core_P, bus.core_Q}), 64'd0);
    checkOutput("rst outputs",    64'({bus.out_gcd, bus.out_p, bus.out_q, bus.out_cycles}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] core-path jobs");
    runJob("5,5",   5,   5, 5,   2,   7);
    runJob("12,8",  12,  8, 4,   8,  13);
    runJob("255,1", 255, 1, 1, 510, 515);

    $display("[TB] zero bypass");
    runJob("0,9", 0, 9, 9, 0, 1);
    runJob("7,0", 7, 0, 7, 0, 1);
    runJob("0,0", 0, 0, 0, 0, 1);

    $display("[TB] back-pressure");
    bus.out_ready = 1'b0;
    applyStimulus(8'd48, 8'd18, 1'b0);
    waitOutValid(lat);
    bus.in_p     = 8'd9;
    bus.in_q     = 8'd6;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("stall hold",
                  64'({bus.out_valid, bus.in_ready, bus.out_gcd, bus.out_p, bus.out_q, bus.out_cycles}),
                  64'({1'b1, 1'b0, 8'd6, 8'd48, 8'd18, 16'd14}));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("after transfer", 64'({bus.out_valid, bus.in_ready}), 64'({1'b0, 1'b1}));
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("pending accepted", 64'({bus.in_ready, bus.out_p, bus.out_q}), 64'({1'b0, 8'd9, 8'd6}));
    waitOutValid(lat);
    checkJob("9,6 pending", 3, 9, 6, 8);
    @(negedge clk);

    $display("[TB] back-to-back");
    applyStimulus(8'd20, 8'd15, 1'b1);
    bus.in_p = 8'd21;
    bus.in_q = 8'd14;
    waitOutValid(lat);
    checkJob("20,15", 5, 20, 15, 10);
    @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    waitOutValid(lat);
    checkJob("21,14", 7, 21, 14, 8);
    checkOutput("21,14 latency", 64'(lat), 64'd13);
    @(negedge clk);

    $display("[TB] reset during RUN");
    applyStimulus(8'd200, 8'd3, 1'b0);
    repeat (10) @(negedge clk);
    checkOutput("in RUN", 64'({bus.core_start, bus.out_valid}), 64'({1'b1, 1'b0}));
    rst = 1'b1;
    #1;
    checkOutput("midrst handshake", 64'({bus.in_ready, bus.core_start, bus.out_valid}), 64'({1'b1, 1'b0, 1'b0}));
    checkOutput("midrst outputs", 64'({bus.out_gcd, bus.out_p, bus.out_q, bus.out_cycles}), 64'd0);
    checkOutput("midrst core_PQ", 64'({bus.core_P, bus.core_Q}), 64'd0);
    checkOutput("midrst core S0", 64'({coreState, bus.core_done}), 64'({C_S0, 1'b0}));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    runJob("9,6 after rst", 9, 6, 3, 8, 13);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
